oled_frame_seq: RTL and testbench

Byte-stream sequencer sitting directly upstream of the SPI serializer that drives the 96x64 16-bit-colour OLED. After reset it emits the panel's fixed init command list, then renders one full frame of the 4x4 piano-tile map per trigger: a window-set header followed by every pixel as two bytes. It advances frames on rising edges of the synchronized "next" button and hands bytes to the serializer over a valid/ready handshake with a D/C flag per byte.

---
 rtl/oled_frame_seq_if.sv | 11 +
 rtl/oled_frame_seq.sv | 148 ++++++++++++++
 tb/tb_oled_frame_seq.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_frame_seq_if.sv
// Byte handshake between the OLED frame sequencer and the SPI serializer.
// One byte moves in any cycle where byte_valid && byte_ready.
interface oled_frame_seq_if;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       byte_dc;

  modport master (output byte_valid, output byte_data, output byte_dc, input byte_ready);
  modport slave  (input byte_valid, input byte_data, input byte_dc, output byte_ready);
endinterface

// File: rtl/oled_frame_seq.sv
// OLED byte sequencer: panel init list once after reset, then one framed
// render of the 4x4 tile map (window header + 96x64 RGB565 pixels) per trigger.
module oled_frame_seq #(
  parameter int          STARTUP_CYCLES = 16,
  parameter logic [15:0] ON_COLOR       = 16'h0000,
  parameter logic [15:0] OFF_COLOR      = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                next_btn_i,
  input  logic [15:0]         tile_map_i,
  oled_frame_seq_if.master    bus,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic [7:0]          frame_cnt_o
);
  localparam int CW = $clog2(STARTUP_CYCLES + 1);

  typedef enum logic [2:0] {S_WAIT, S_INIT, S_HDR, S_PIX, S_IDLE} state_e;

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]  idx_q;
  logic [15:0] map_q;
  logic        pend_q, btn_q;
  logic        valid_q, dc_q, busy_q, done_q;
  logic [7:0]  data_q, fcnt_q;
  logic        phase_q, phase_d;
  logic [6:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic [4:0]  xs_q, xs_d;
  logic [3:0]  ys_q, ys_d;
  logic [1:0]  tc_q, tc_d, tr_q, tr_d;
  logic        rise, pend_set, xfer, last_pix, to_hdr;

  function automatic logic [7:0] init_byte(input logic [3:0] i);
    case (i)
      4'd0: return 8'hAE;  4'd1: return 8'hA0;  4'd2: return 8'h72;
      4'd3: return 8'hA1;  4'd4: return 8'h00;  4'd5: return 8'hA2;
      4'd6: return 8'h00;  4'd7: return 8'hA4;  4'd8: return 8'hA8;
      4'd9: return 8'h3F;  4'd10: return 8'hAD; 4'd11: return 8'h8E;
      4'd12: return 8'hAF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [3:0] i);
    case (i)
      4'd0: return 8'h15; 4'd1: return 8'h00; 4'd2: return 8'h5F;
      4'd3: return 8'h75; 4'd4: return 8'h00; 4'd5: return 8'h3F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] pix_byte(input logic [15:0] map, input logic [1:0] tr,
                                          input logic [1:0] tc, input logic ph);
    logic [15:0] col;
    col = map[{tr, tc}] ? ON_COLOR : OFF_COLOR;
    return ph ? col[7:0] : col[15:8];
  endfunction

  always_comb begin
    rise     = next_btn_i & ~btn_q;
    pend_set = pend_q | (rise & (state_q != S_WAIT) & (state_q != S_INIT));
    xfer     = valid_q & bus.byte_ready;
    last_pix = (y_q == 6'd63) && (x_q == 7'd95) && phase_q;
    to_hdr   = ((state_q == S_INIT) && xfer && (idx_q == 4'd12)) ||
               ((state_q == S_PIX) && xfer && last_pix && pend_set) ||
               ((state_q == S_IDLE) && pend_q);
    // Tile row/column come from sub-counters wrapping at 24 px and 16 lines.
    phase_d = ~phase_q;
    x_d = x_q;  y_d = y_q;  xs_d = xs_q;  ys_d = ys_q;  tc_d = tc_q;  tr_d = tr_q;
    if (phase_q) begin
      if (x_q == 7'd95) begin
        x_d = 7'd0;  xs_d = 5'd0;  tc_d = 2'd0;  y_d = y_q + 6'd1;
        if (ys_q == 4'd15) begin ys_d = 4'd0; tr_d = tr_q + 2'd1; end
        else ys_d = ys_q + 4'd1;
      end else begin
        x_d = x_q + 7'd1;
        if (xs_q == 5'd23) begin xs_d = 5'd0; tc_d = tc_q + 2'd1; end
        else xs_d = xs_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT;  cnt_q <= '0;  idx_q <= '0;  map_q <= '0;
      pend_q <= 1'b0;  btn_q <= 1'b0;  valid_q <= 1'b0;  data_q <= 8'h00;
      dc_q <= 1'b0;  busy_q <= 1'b1;  done_q <= 1'b0;  fcnt_q <= 8'h00;
      phase_q <= 1'b0;  x_q <= '0;  y_q <= '0;  xs_q <= '0;  ys_q <= '0;
      tc_q <= '0;  tr_q <= '0;
    end else begin
      btn_q  <= next_btn_i;
      done_q <= 1'b0;
      pend_q <= to_hdr ? 1'b0 : pend_set;
      if ((state_q == S_PIX) && xfer && last_pix) begin
        done_q <= 1'b1;
        fcnt_q <= fcnt_q + 8'd1;
      end
      if (to_hdr) begin
        state_q <= S_HDR;  idx_q <= 4'd0;  map_q <= tile_map_i;
        valid_q <= 1'b1;  data_q <= hdr_byte(4'd0);  dc_q <= 1'b0;  busy_q <= 1'b1;
      end else begin
        case (state_q)
          S_WAIT: begin
            if (cnt_q == CW'(STARTUP_CYCLES)) begin
              state_q <= S_INIT;  idx_q <= 4'd0;
              valid_q <= 1'b1;  data_q <= init_byte(4'd0);  dc_q <= 1'b0;
            end else cnt_q <= cnt_q + CW'(1);
          end
          S_INIT: if (xfer) begin
            idx_q  <= idx_q + 4'd1;
            data_q <= init_byte(idx_q + 4'd1);
          end
          S_HDR: if (xfer) begin
            if (idx_q == 4'd5) begin
              state_q <= S_PIX;  phase_q <= 1'b0;  x_q <= '0;  y_q <= '0;
              xs_q <= '0;  ys_q <= '0;  tc_q <= '0;  tr_q <= '0;
              data_q <= pix_byte(map_q, 2'd0, 2'd0, 1'b0);  dc_q <= 1'b1;
            end else begin
              idx_q  <= idx_q + 4'd1;
              data_q <= hdr_byte(idx_q + 4'd1);
            end
          end
          S_PIX: if (xfer) begin
            if (last_pix) begin
              state_q <= S_IDLE;  valid_q <= 1'b0;  busy_q <= 1'b0;
            end else begin
              phase_q <= phase_d;  x_q <= x_d;  y_q <= y_d;  xs_q <= xs_d;
              ys_q <= ys_d;  tc_q <= tc_d;  tr_q <= tr_d;
              data_q <= pix_byte(map_q, tr_d, tc_d, phase_d);
            end
          end
          S_IDLE: ;
          default: state_q <= S_WAIT;
        endcase
      end
    end
  end

  assign bus.byte_valid = valid_q;
  assign bus.byte_data  = data_q;
  assign bus.byte_dc    = dc_q;
  assign busy_o         = busy_q;
  assign frame_done_o   = done_q;
  assign frame_cnt_o    = fcnt_q;
endmodule

// File: tb/tb_oled_frame_seq.sv
// Directed bench for oled_frame_seq: init list, frame contents, handshake
// stalls, trigger merging and mid-frame reset.
module tb_oled_frame_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        next_btn = 1'b0;
  logic [15:0] tile_map = 16'h0000;
  logic        busy, frame_done;
  logic [7:0]  frame_cnt;
  int          errors = 0;
  int          checks = 0;
  int          stall_viol = 0;
  logic [7:0]  cap_data [0:12306];
  logic        cap_dc   [0:12306];

  oled_frame_seq_if bus ();

  oled_frame_seq #(.STARTUP_CYCLES(16), .ON_COLOR(16'h0000), .OFF_COLOR(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .next_btn_i(next_btn), .tile_map_i(tile_map),
    .bus(bus.master), .busy_o(busy), .frame_done_o(frame_done), .frame_cnt_o(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_init(input int k);
    case (k)
      0: return 8'hAE;  1: return 8'hA0;  2: return 8'h72;  3: return 8'hA1;
      4: return 8'h00;  5: return 8'hA2;  6: return 8'h00;  7: return 8'hA4;
      8: return 8'hA8;  9: return 8'h3F;  10: return 8'hAD; 11: return 8'h8E;
      12: return 8'hAF;
      default: return 8'hXX;
    endcase
  endfunction

  // {dc, data} of transfer k of a frame (header then pixels), from x/y division.
  function automatic logic [8:0] exp_frame(input logic [15:0] map, input int k);
    int p, pix, x, y;
    logic [15:0] col;
    case (k)
      0: return 9'h015;  1: return 9'h000;  2: return 9'h05F;
      3: return 9'h075;  4: return 9'h000;  5: return 9'h03F;
      default: ;
    endcase
    p = k - 6;  pix = p / 2;  x = pix % 96;  y = pix / 96;
    col = map[4 * (y / 16) + x / 24] ? 16'h0000 : 16'hFFFF;
    return {1'b1, (p % 2 == 1) ? col[7:0] : col[15:8]};
  endfunction

  // Accepts n bytes into cap_* from index start; leaves byte_ready low.
  task automatic capture(input int start, input int n, input int low_pct, output int got);
    int cyc;
    logic r, pv, pr, pdc;
    logic [7:0] pd;
    got = 0;  cyc = 0;  pv = 1'b0;  pr = 1'b1;  pd = 8'h00;  pdc = 1'b0;
    while (got < n && cyc < n * 4 + 200) begin
      @(negedge clk);
      cyc++;
      r = ($urandom_range(99) >= low_pct);
      bus.byte_ready = r;
      if (pv && !pr && (bus.byte_valid !== 1'b1 || bus.byte_data !== pd || bus.byte_dc !== pdc))
        stall_viol++;
      if (bus.byte_valid === 1'b1 && r) begin
        cap_data[start + got] = bus.byte_data;
        cap_dc[start + got]   = bus.byte_dc;
        got++;
      end
      pv = bus.byte_valid;  pr = r;  pd = bus.byte_data;  pdc = bus.byte_dc;
    end
    @(posedge clk);
    #1 bus.byte_ready = 1'b0;
  endtask

  task automatic test_reset();
    int first;
    rst = 1'b1;  bus.byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.byte_valid, bus.byte_data, bus.byte_dc} !== 10'h000) begin
      errors++;
      $display("FAIL reset_bus: got v=%b d=%h dc=%b, want v=0 d=00 dc=0", bus.byte_valid, bus.byte_data, bus.byte_dc);
    end
    checks++;
    if ({busy, frame_done, frame_cnt} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b cnt=%0d, want 1 0 0", busy, frame_done, frame_cnt);
    end
    rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      @(negedge clk);
      if (bus.byte_valid === 1'b1) first = k;
    end
    checks++;
    if (first != 17) begin
      errors++;
      $display("FAIL startup_latency: got %0d, want 17", first);
    end
    checks++;
    if (bus.byte_data !== 8'hAE || bus.byte_dc !== 1'b0) begin
      errors++;
      $display("FAIL first_byte: got %h dc=%b, want AE dc=0", bus.byte_data, bus.byte_dc);
    end
  endtask

  task automatic test_init_frame();
    int got, bad, first_bad;
    next_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    next_btn = 1'b0;
    checks++;
    if (bus.byte_valid !== 1'b1 || bus.byte_data !== 8'hAE) begin
      errors++;
      $display("FAIL init_hold: got v=%b d=%h, want v=1 d=AE", bus.byte_valid, bus.byte_data);
    end
    capture(0, 12307, 0, got);
    checks++;
    if (got != 12307) begin
      errors++;
      $display("FAIL init_frame_count: got %0d bytes, want 12307", got);
    end
    bad = 0;  first_bad = -1;
    for (int k = 0; k < 13; k++)
      if (cap_data[k] !== exp_init(k) || cap_dc[k] !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_list: %0d bad bytes, first at %0d, want 0 bad", bad, first_bad);
    end
    bad = 0;  first_bad = -1;
    for (int k = 0; k < 12294; k++)
      if ({cap_dc[k + 13], cap_data[k + 13]} !== exp_frame(16'h0000, k)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL first_frame: %0d bad bytes, first at %0d, want 0 bad", bad, first_bad);
    end
    @(negedge clk);
    checks++;
    if ({frame_done, frame_cnt, busy} !== {1'b1, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL first_done: got done=%b cnt=%0d busy=%b, want 1 1 0", frame_done, frame_cnt, busy);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%b, want 0", frame_done);
    end
    repeat (20) @(negedge clk);
    checks++;
    if ({busy, frame_cnt, bus.byte_valid} !== {1'b0, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL init_edge_ignored: got busy=%b cnt=%0d v=%b, want 0 1 0", busy, frame_cnt, bus.byte_valid);
    end
  endtask

  task automatic test_random_ready();
    int got, bad, first_bad, black;
    tile_map = 16'h0001;
    @(negedge clk);
    next_btn = 1'b1;
    @(negedge clk);
    next_btn = 1'b0;
    checks++;
    if (bus.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL trig_t1: got v=%b, want 0", bus.byte_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.byte_valid, bus.byte_data, busy} !== {1'b1, 8'h15, 1'b1}) begin
      errors++;
      $display("FAIL trig_t2: got v=%b d=%h busy=%b, want 1 15 1", bus.byte_valid, bus.byte_data, busy);
    end
    stall_viol = 0;
    capture(0, 12294, 30, got);
    checks++;
    if (got != 12294) begin
      errors++;
      $display("FAIL rnd_count: got %0d bytes, want 12294", got);
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL rnd_stall_stable: got %0d violations, want 0", stall_viol);
    end
    bad = 0;  first_bad = -1;  black = 0;
    for (int k = 0; k < 12294; k++)
      if ({cap_dc[k], cap_data[k]} !== exp_frame(16'h0001, k)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    for (int k = 6; k < 12294; k += 2)
      if (cap_data[k] === 8'h00 && cap_data[k + 1] === 8'h00) black++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rnd_stream: %0d bad bytes, first at %0d, want 0 bad", bad, first_bad);
    end
    checks++;
    if (black != 384) begin
      errors++;
      $display("FAIL black_pixels: got %0d, want 384", black);
    end
    @(negedge clk);
    checks++;
    if ({frame_done, frame_cnt} !== {1'b1, 8'd2}) begin
      errors++;
      $display("FAIL rnd_done: got done=%b cnt=%0d, want 1 2", frame_done, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int g1, g2, bad, first_bad;
    tile_map = 16'h8421;
    @(negedge clk) next_btn = 1'b1;
    @(negedge clk) next_btn = 1'b0;
    capture(0, 6, 0, g1);
    tile_map = 16'hF00F;
    repeat (2) begin
      @(negedge clk) next_btn = 1'b1;
      @(negedge clk) next_btn = 1'b0;
    end
    capture(6, 12288, 0, g2);
    bad = 0;  first_bad = -1;
    for (int k = 0; k < 12294; k++)
      if ({cap_dc[k], cap_data[k]} !== exp_frame(16'h8421, k)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    checks++;
    if (g1 + g2 != 12294 || bad != 0) begin
      errors++;
      $display("FAIL b2b_frame1: got %0d bytes %0d bad (first %0d), want 12294 and 0", g1 + g2, bad, first_bad);
    end
    @(negedge clk);
    checks++;
    if ({frame_done, frame_cnt, busy, bus.byte_valid, bus.byte_data} !== {1'b1, 8'd3, 1'b1, 1'b1, 8'h15}) begin
      errors++;
      $display("FAIL b2b_chain: got done=%b cnt=%0d busy=%b v=%b d=%h, want 1 3 1 1 15",
               frame_done, frame_cnt, busy, bus.byte_valid, bus.byte_data);
    end
    capture(0, 6, 0, g1);
    tile_map = 16'h0000;
    capture(6, 12288, 0, g2);
    bad = 0;  first_bad = -1;
    for (int k = 0; k < 12294; k++)
      if ({cap_dc[k], cap_data[k]} !== exp_frame(16'hF00F, k)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    checks++;
    if (g1 + g2 != 12294 || bad != 0) begin
      errors++;
      $display("FAIL b2b_frame2_latched: got %0d bytes %0d bad (first %0d), want 12294 and 0", g1 + g2, bad, first_bad);
    end
    @(negedge clk);
    checks++;
    if ({frame_done, frame_cnt, busy} !== {1'b1, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL b2b_done: got done=%b cnt=%0d busy=%b, want 1 4 0", frame_done, frame_cnt, busy);
    end
    repeat (30) @(negedge clk);
    checks++;
    if ({busy, frame_cnt, bus.byte_valid} !== {1'b0, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL b2b_merged: got busy=%b cnt=%0d v=%b, want 0 4 0", busy, frame_cnt, bus.byte_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    int got, bad, first;
    tile_map = 16'h5A3C;
    @(negedge clk) next_btn = 1'b1;
    @(negedge clk) next_btn = 1'b0;
    capture(0, 5006, 0, got);
    bad = 0;
    for (int k = 0; k < 5006; k++)
      if ({cap_dc[k], cap_data[k]} !== exp_frame(16'h5A3C, k)) bad++;
    checks++;
    if (got != 5006 || bad != 0) begin
      errors++;
      $display("FAIL partial_frame: got %0d bytes %0d bad, want 5006 and 0", got, bad);
    end
    @(negedge clk);
    checks++;
    if ({bus.byte_valid, bus.byte_dc, bus.byte_data} !== {1'b1, exp_frame(16'h5A3C, 5006)}) begin
      errors++;
      $display("FAIL pix5000_present: got v=%b dc=%b d=%h, want v=1 dc=1 d=%h",
               bus.byte_valid, bus.byte_dc, bus.byte_data, exp_frame(16'h5A3C, 5006) & 9'hFF);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.byte_valid, frame_cnt, busy, frame_done} !== {1'b0, 8'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got v=%b cnt=%0d busy=%b done=%b, want 0 0 1 0",
               bus.byte_valid, frame_cnt, busy, frame_done);
    end
    rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      @(negedge clk);
      if (bus.byte_valid === 1'b1) first = k;
    end
    checks++;
    if (first != 17 || bus.byte_data !== 8'hAE) begin
      errors++;
      $display("FAIL restart_init: got latency %0d byte %h, want 17 AE", first, bus.byte_data);
    end
  endtask

  initial begin
    bus.byte_ready = 1'b0;
    test_reset();
    test_init_frame();
    test_random_ready();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
